// File: rtl/moore_10110.sv
// Moore detector for serial pattern 1-0-1-1-0 with saturating match count.
// Define MOORE10110_STATE_OUT_EN to expose the state encoding on state_o.
module moore_10110 #(
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
`ifdef MOORE10110_STATE_OUT_EN
  output logic [2:0]       state_o,
`endif
  output logic             w,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DET  = 3'd5
  } state_t;

  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Encodings 6 and 7 fall into the default arm and recover to IDLE.
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = j ? S1 : IDLE;
      S1:      state_nx = j ? S1 : S2;
      S2:      state_nx = j ? S3 : IDLE;
      S3:      state_nx = j ? S4 : S2;
      S4:      state_nx = j ? S1 : DET;
      DET: begin
        if (j) state_nx = OVERLAP ? S3 : S1;
        else   state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_cnt <= '0;
    else if (state_nx == DET && match_cnt != {CNT_W{1'b1}})
      match_cnt <= match_cnt + 1'b1;
  end

  assign w = (state == DET);

`ifdef MOORE10110_STATE_OUT_EN
  assign state_o = state;
`endif

endmodule

// File: tb/tb_moore_10110.sv
// Directed bench for moore_10110: overlap, non-overlap and saturating builds
// share one stimulus stream.
module tb_moore_10110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       j   = 1'b0;
  logic       w, w_no, w_sat;
  logic [7:0] cnt, cnt_no;
  logic [1:0] cnt_sat;
`ifdef MOORE10110_STATE_OUT_EN
  logic [2:0] st, st_no, st_sat;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  moore_10110 #(.OVERLAP(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .j(j),
`ifdef MOORE10110_STATE_OUT_EN
    .state_o(st),
`endif
    .w(w), .match_cnt(cnt)
  );

  moore_10110 #(.OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .j(j),
`ifdef MOORE10110_STATE_OUT_EN
    .state_o(st_no),
`endif
    .w(w_no), .match_cnt(cnt_no)
  );

  moore_10110 #(.OVERLAP(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .j(j),
`ifdef MOORE10110_STATE_OUT_EN
    .state_o(st_sat),
`endif
    .w(w_sat), .match_cnt(cnt_sat)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    j = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int n, input logic [15:0] bits,
                     input logic [15:0] we, input logic [15:0] wne);
    for (int k = 0; k < n; k++) begin
      step(bits[n-1-k]);
      check($sformatf("%s w[%0d]", tag, k), {31'd0, w}, {31'd0, we[n-1-k]});
      check($sformatf("%s w_no[%0d]", tag, k), {31'd0, w_no},
            {31'd0, wne[n-1-k]});
    end
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst = 1'b0;
    j   = 1'b0;
    #1;
    check({tag, " w"}, {31'd0, w}, 32'd0);
    check({tag, " cnt"}, {24'd0, cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Held reset while j toggles and clock runs
    for (int k = 0; k < 4; k++) begin
      step(k[0]);
      check($sformatf("rst_hold w[%0d]", k), {31'd0, w}, 32'd0);
      check($sformatf("rst_hold cnt[%0d]", k), {24'd0, cnt}, 32'd0);
      check($sformatf("rst_hold cnt_sat[%0d]", k), {30'd0, cnt_sat}, 32'd0);
    end

    // Release; first edge with j=1 enters S1
    @(negedge clk);
    rst = 1'b1;
    j   = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge w", {31'd0, w}, 32'd0);
`ifdef MOORE10110_STATE_OUT_EN
    check("first_edge state", {29'd0, st}, 32'd1);
`endif

    // Remainder of 1,0,1,1,0
    run("basic", 4, 16'b0110, 16'b0001, 16'b0001);
    check("basic cnt", {24'd0, cnt}, 32'd1);
    step(1'b0);
    check("basic w_after", {31'd0, w}, 32'd0);

    rst_pulse("rst_ovl");
    run("ovl", 9, 16'b010110110, 16'b000001001, 16'b000001000);
    check("ovl cnt", {24'd0, cnt}, 32'd2);
    check("ovl cnt_no", {24'd0, cnt_no}, 32'd1);

    rst_pulse("rst_near");
    run("near", 12, 16'b100111010111, 16'd0, 16'd0);
    check("near cnt", {24'd0, cnt}, 32'd0);
    check("near cnt_no", {24'd0, cnt_no}, 32'd0);

    rst_pulse("rst_sat");
    for (int d = 1; d <= 5; d++) begin
      run($sformatf("sat%0d", d), 5, 16'b10110, 16'b00001, 16'b00001);
      check($sformatf("sat cnt_sat[%0d]", d), {30'd0, cnt_sat},
            (d < 3) ? d : 3);
    end
    check("sat cnt", {24'd0, cnt}, 32'd5);

    // Asynchronous reset in the middle of a pattern
    run("mid", 3, 16'b101, 16'd0, 16'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid w", {31'd0, w}, 32'd0);
    check("mid cnt", {24'd0, cnt}, 32'd0);
    check("mid cnt_no", {24'd0, cnt_no}, 32'd0);
    check("mid cnt_sat", {30'd0, cnt_sat}, 32'd0);
`ifdef MOORE10110_STATE_OUT_EN
    check("mid state", {29'd0, st}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
